// File: rtl/npu_pkg.sv
// Shared types for the NPU unified-buffer streaming blocks.
package npu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } stream_state_e;

  localparam int CMD_LEN_W = 16;

endpackage

// File: rtl/defines.sv
// Build-wide default sizes for the NPU datapath blocks.
`ifndef ARRAY_SIZE
`define ARRAY_SIZE 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef UB_ADDR_WIDTH
`define UB_ADDR_WIDTH 16
`endif

// File: rtl/row_hold_reg.sv
// Single-entry row buffer: parks a returned UB row while downstream is stalled.
module row_hold_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         unload,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] data_out,
  output logic         valid
);

  // Load has priority; a load and unload never coincide in the streamer.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
      valid    <= 1'b0;
    end else if (load) begin
      data_out <= data_in;
      valid    <= 1'b1;
    end else if (unload) begin
      valid    <= 1'b0;
    end
  end

endmodule

// File: rtl/ub_row_streamer.sv
// Streams L consecutive unified-buffer rows into the systolic skewer, then
// flushes it with N zero rows. Tolerates downstream stall via a hold register.
`ifndef ARRAY_SIZE
`define ARRAY_SIZE 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef UB_ADDR_WIDTH
`define UB_ADDR_WIDTH 16
`endif

module ub_row_streamer
  import npu_pkg::*;
#(
  parameter int N          = `ARRAY_SIZE,
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int ADDR_WIDTH = `UB_ADDR_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_base_addr,
  input  logic [CMD_LEN_W-1:0]    cmd_len,
  output logic                    ub_rd_en,
  output logic [ADDR_WIDTH-1:0]   ub_rd_addr,
  input  logic [N*DATA_WIDTH-1:0] ub_rd_data,
  input  logic                    stall,
  output logic [N*DATA_WIDTH-1:0] row_data_flat,
  output logic                    first_out,
  output logic                    last_out,
  output logic                    skew_en,
  output logic                    busy,
  output logic                    done
);

  localparam int RW  = N * DATA_WIDTH;
  localparam int DCW = $clog2(N + 1);

  stream_state_e          state, state_nxt;
  logic [ADDR_WIDTH-1:0]  base;
  logic [CMD_LEN_W-1:0]   len;
  logic [CMD_LEN_W-1:0]   issued;
  logic [CMD_LEN_W-1:0]   emitted;
  logic [DCW-1:0]         drain_cnt;
  logic                   rd_pend;
  logic                   rd_en;
  logic                   present;
  logic                   hold_valid, hold_load, hold_unload;
  logic [RW-1:0]          hold_data;

  // Returned data is parked when it arrives under stall; the parked row leaves
  // on the first stall-low cycle, so the register is always free again by the
  // time the next read (issued that same cycle) returns.
  assign hold_load   = rd_pend && stall;
  assign hold_unload = hold_valid && !stall;
  assign present     = (state == ST_STREAM) && !stall && (hold_valid || rd_pend);

  row_hold_reg #(.W(RW)) u_hold (
    .clk      (clk),
    .rst      (rst),
    .load     (hold_load),
    .unload   (hold_unload),
    .data_in  (ub_rd_data),
    .data_out (hold_data),
    .valid    (hold_valid)
  );

  assign cmd_ready  = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign ub_rd_en   = rd_en;
  assign ub_rd_addr = rd_en ? base + ADDR_WIDTH'(issued) : '0;

  // Next-state and per-cycle outputs.
  always_comb begin
    state_nxt     = state;
    rd_en         = 1'b0;
    skew_en       = 1'b0;
    first_out     = 1'b0;
    last_out      = 1'b0;
    row_data_flat = '0;
    done          = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) state_nxt = (cmd_len == '0) ? ST_DONE : ST_STREAM;
      end
      ST_STREAM: begin
        rd_en = (issued != len) && !stall && (!hold_valid || hold_unload);
        if (present) begin
          skew_en       = 1'b1;
          row_data_flat = hold_valid ? hold_data : ub_rd_data;
          first_out     = (emitted == '0);
          last_out      = (emitted == len - 1'b1);
          if (last_out) state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        skew_en = !stall;
        if (!stall && drain_cnt == DCW'(N - 1)) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, command latch and progress counters; reset drops any in-flight read.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      base      <= '0;
      len       <= '0;
      issued    <= '0;
      emitted   <= '0;
      drain_cnt <= '0;
      rd_pend   <= 1'b0;
    end else begin
      state   <= state_nxt;
      rd_pend <= rd_en;
      if (state == ST_IDLE && cmd_valid) begin
        base      <= cmd_base_addr;
        len       <= cmd_len;
        issued    <= '0;
        emitted   <= '0;
        drain_cnt <= '0;
      end
      if (rd_en)   issued  <= issued + 1'b1;
      if (present) emitted <= emitted + 1'b1;
      if (state == ST_DRAIN && !stall) drain_cnt <= drain_cnt + DCW'(1);
    end
  end

endmodule

// File: doc/ub_row_streamer.md
UB_ROW_STREAMER -- requirements
Module: ub_row_streamer

Interface
REQ-001 Parameter N, default `ARRAY_SIZE, systolic array dimension (elements per row).
REQ-002 Parameter DATA_WIDTH, default `DATA_WIDTH, element width.
REQ-003 Parameter ADDR_WIDTH, default `UB_ADDR_WIDTH, unified-buffer address width.
REQ-004 Port clk  input  1  sole clock; single clock domain, all logic on rising edge.
REQ-005 Port rst  input  1  reset, synchronous and active-high.
REQ-006 Ports cmd_valid / cmd_ready  input / output  1 / 1  command handshake; accept on cycle both high.
REQ-007 Port cmd_base_addr  input  ADDR_WIDTH  UB address of row 0.
REQ-008 Port cmd_len  input  16  number of rows L, 0..65535.
REQ-009 Ports ub_rd_en / ub_rd_addr  output  1 / ADDR_WIDTH  UB read request.
REQ-010 Port ub_rd_data  input  N*DATA_WIDTH  read data, valid exactly 1 cycle after ub_rd_en; element i at bits [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH].
REQ-011 Port stall  input  1  downstream hold; no row advances while high.
REQ-012 Port row_data  output  N x DATA_WIDTH  row vector into skewer data_in.
REQ-013 Ports first_out / last_out  output  1 / 1  row 0 / row L-1 markers, into skewer first_in / last_in.
REQ-014 Port skew_en  output  1  skewer enable; high when row_data is to be consumed.
REQ-015 Ports busy / done  output  1 / 1  command in progress / 1-cycle completion pulse.

Function
REQ-016 FSM states IDLE, STREAM, DRAIN, DONE; cmd_ready = (state==IDLE).
REQ-017 IDLE: on accept, latch base/len, clear counters; L=0 -> DONE, else STREAM.
REQ-018 STREAM: issue one read per cycle at base+issued_count, only when stall low and hold register empty; stop after L reads; address wraps modulo 2^ADDR_WIDTH.
REQ-019 Returned row presented on row_data with skew_en=1 in return cycle if stall low; if stall high in return cycle, row captured into one-entry hold register and presented on first stall-low cycle.
REQ-020 first_out high only with row 0's skew_en cycle; last_out only with row L-1's; both in same cycle when L=1.
REQ-021 Markers and data never emitted while stall high; skew_en=0, row_data=0 whenever no row presented.
REQ-022 After row L-1 emitted -> DRAIN: N cycles of row_data=0, skew_en=1, markers 0; stalled cycles not counted.
REQ-023 DRAIN complete -> DONE: done=1 one cycle, then IDLE; busy=1 in STREAM, DRAIN, DONE.
REQ-024 No-stall timing, accept at cycle 0: reads cycles 1..L; row k out at cycle 2+k; drain cycles 2+L..1+L+N; done at cycle 2+L+N; cmd_ready high at 3+L+N.
REQ-025 cmd_valid while busy ignored, no effect on state.

Reset
REQ-026 rst high at any clock edge, including mid-STREAM/DRAIN: state=IDLE, counters and hold register cleared, in-flight read discarded.
REQ-027 Reset values: cmd_ready=1; ub_rd_en, skew_en, first_out, last_out, busy, done=0; ub_rd_addr=0; row_data all 0.

Structure
REQ-028 State enum typedef in shared package npu_pkg; N, DATA_WIDTH, ADDR_WIDTH defaults from defines.sv.
REQ-029 One sub-module, row_hold_reg: single-entry N*DATA_WIDTH hold register with valid flag and load/unload.
REQ-030 row_data exposed flattened as row_data_flat (N*DATA_WIDTH) for Verilator, same packing as ub_rd_data.

Verification
REQ-031 N=4, base 0x10, L=4, no stall -> reads 0x10..0x13 cycles 1..4; rows cycles 2..5; first_out cycle 2, last_out cycle 5; skew_en 2..9; done cycle 10.
REQ-032 L=1 -> single row with first_out=last_out=1 same cycle; 4 drain cycles; done cycle 7.
REQ-033 L=0 -> no ub_rd_en, no skew_en, no markers; done cycle 1; cmd_ready high cycle 2.
REQ-034 L=4, stall high cycles 3..5 -> row 1 held, re-presented cycle 6, no read issued cycles 3..5, no row dropped or duplicated; done cycle 13.
REQ-035 rst in cycle 4 of L=8 command -> next cycle all outputs at reset values; new command then accepted and completes per REQ-024 timing.
REQ-036 Base 0xFFFE (ADDR_WIDTH=16), L=3 -> addresses 0xFFFE, 0xFFFF, 0x0000.
